el2_trace_capture: RTL and testbench
====================================

EL2_TRACE_CAPTURE -- requirements
Module: el2_trace_capture

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered trace records; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  core clock; every flop SHALL be on its rising edge.
REQ-003 rst_l  input  1  reset; asynchronous assert, active-low; SHALL be the only reset in the block.
REQ-004 trace_pkt  input  el2_trace_pkt_t (104)  per-cycle retirement trace from the core.
REQ-005 capture_en  input  1  1 = accept trace records; 0 = ignore trace_pkt.
REQ-006 out_valid  output  1  a word is presented on out_data.
REQ-007 out_ready  input  1  the downstream sink accepts the presented word.
REQ-008 out_data  output  32  serialized trace word.
REQ-009 out_last  output  1  out_data is the final word of a record.
REQ-010 busy  output  1  FIFO non-empty or a record is mid-transfer.

Function
REQ-011 Push: a record SHALL be captured when trace_pkt.trace_rv_i_valid_ip=1, capture_en=1, and the registered FIFO occupancy is below DEPTH; a pop in the same cycle SHALL NOT free space for that push.
REQ-012 Drop: a valid trace packet with capture_en=1 and a full FIFO SHALL be discarded, and pend_drop SHALL increment, saturating at 255.
REQ-013 Each captured record SHALL store: insn, address, tval, exception, ecause, interrupt, seq[7:0], and drop[7:0]=pend_drop.
REQ-014 pend_drop SHALL clear to 0 in the same cycle a record is captured. Capture and drop are mutually exclusive in a cycle.
REQ-015 seq SHALL increment by 1 per captured record and wrap 255->0; the first record after reset SHALL carry seq=0.
REQ-016 Serializer FSM states: IDLE, HDR, ADDR, INSN, TVAL.
REQ-017 FSM transitions:
  - IDLE->HDR when the FIFO is non-empty.
  - HDR->ADDR, ADDR->INSN on a word handshake.
  - INSN->TVAL on a handshake if exception|interrupt; else INSN->IDLE or INSN->HDR.
  - TVAL->IDLE or TVAL->HDR on a handshake.
  - Exit to HDR when another record is queued, else IDLE.
REQ-018 Word handshake is out_valid & out_ready. out_valid SHALL be 1 in HDR/ADDR/INSN/TVAL and 0 in IDLE. out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 HDR word fields:
  - [31:24]=8'hA5
  - [23]=exception
  - [22]=interrupt
  - [21:17]=ecause
  - [16]=(drop!=0)
  - [15:8]=drop
  - [7:0]=seq
REQ-020 ADDR word = address; INSN word = insn; TVAL word = tval.
REQ-021 out_last SHALL be 1 on the INSN word when exception=interrupt=0, and on the TVAL word otherwise; 0 on all other words.
REQ-022 The head record SHALL pop on the out_last handshake; back-to-back records SHALL have no idle cycle between them when out_ready is held 1.
REQ-023 Deasserting capture_en SHALL NOT abort a record in flight or flush the FIFO; queued records SHALL drain normally.
REQ-024 Latency: a record pushed into an empty, idle block SHALL present HDR with out_valid=1 in the cycle after capture.
REQ-025 busy SHALL be 1 when the occupancy is nonzero or the FSM is not in IDLE.

Reset
REQ-026 On rst_l=0, the following SHALL clear to 0 immediately:
  - out_valid, out_last, out_data, busy
  - FSM=IDLE
  - occupancy, read/write pointers, seq, pend_drop
REQ-027 An asserted reset mid-record SHALL discard all buffered and in-flight data; no partial record SHALL be resumed after release.

Verification
REQ-028 Single non-exception record, out_ready=1: address=0x0000_1000, insn=0x0000_0013 -> words 0xA500_0000, 0x0000_1000, 0x0000_0013; out_last on the third word; busy then falls.
REQ-029 Exception record: ecause=2, exception=1, tval=0xDEAD_BEEF, seq=1 -> HDR=0xA584_0001, then ADDR, INSN, and TVAL=0xDEAD_BEEF with out_last=1.
REQ-030 Overflow: DEPTH=4 with out_ready=0 and 7 consecutive valid packets -> 4 captured, pend_drop=3. Then out_ready=1 and one more packet -> the fifth record's HDR has [16]=1 and [15:8]=0x03.
REQ-031 Backpressure: toggle out_ready randomly -> every word is stable while stalled, and word order and count match the reference model exactly.
REQ-032 Wrap: 260 records -> seq runs 0..255 and then 0..3; pend_drop saturates at 255 under sustained overflow.
REQ-033 Reset mid-ADDR word with 2 records queued -> outputs are 0 immediately; after release, the next record carries seq=0 and drop=0.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared type for the core's per-cycle retirement trace (104 bits).
package el2_pkg;

    typedef struct packed {
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_valid_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } el2_trace_pkt_t;

endpackage

// File: rtl/el2_trace_capture.sv
// Buffers retired-instruction trace records in a small FIFO and serializes each one
// as HDR/ADDR/INSN[/TVAL] 32-bit words over a valid/ready stream.
module el2_trace_capture
    import el2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_l,
    input  el2_trace_pkt_t trace_pkt,
    input  logic           capture_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic           out_last,
    output logic           busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic [31:0] tval;
        logic        exc;
        logic [4:0]  ecause;
        logic        intr;
        logic [7:0]  seq;
        logic [7:0]  drop;
    } rec_t;

    typedef enum logic [2:0] {StIdle, StHdr, StAddr, StInsn, StTval} state_e;

    rec_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      seq_q, seq_d, pend_drop_q, pend_drop_d;
    state_e          state_q, state_d, next_rec;
    logic            pkt_valid, push, drop, hs, pop;
    rec_t            head, new_rec;

    // Space is judged on registered occupancy only; a same-cycle pop never admits a push.
    assign pkt_valid = trace_pkt.trace_rv_i_valid_ip & capture_en;
    assign push      = pkt_valid & (count_q < CntW'(DEPTH));
    assign drop      = pkt_valid & ~push;

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (state_q != StIdle);
    assign hs        = out_valid & out_ready;
    assign pop       = hs & out_last;
    assign count_d   = count_q + CntW'(push) - CntW'(pop);
    assign next_rec  = (count_d != '0) ? StHdr : StIdle;
    assign busy      = (count_q != '0) | (state_q != StIdle);

    assign new_rec = '{
        insn:   trace_pkt.trace_rv_i_insn_ip,
        addr:   trace_pkt.trace_rv_i_address_ip,
        tval:   trace_pkt.trace_rv_i_tval_ip,
        exc:    trace_pkt.trace_rv_i_exception_ip,
        ecause: trace_pkt.trace_rv_i_ecause_ip,
        intr:   trace_pkt.trace_rv_i_interrupt_ip,
        seq:    seq_q,
        drop:   pend_drop_q
    };

    always_comb begin
        seq_d       = seq_q;
        pend_drop_d = pend_drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            seq_d       = seq_q + 8'd1;
            pend_drop_d = 8'd0;
            wr_ptr_d    = wr_ptr_q + PtrW'(1);
        end else if (drop && pend_drop_q != 8'hFF) begin
            pend_drop_d = pend_drop_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_d != '0) state_d = StHdr;
            StHdr:   if (hs) state_d = StAddr;
            StAddr:  if (hs) state_d = StInsn;
            StInsn:  if (hs) state_d = (head.exc | head.intr) ? StTval : next_rec;
            StTval:  if (hs) state_d = next_rec;
            default: state_d = StIdle;
        endcase
    end

    // Words come straight from the head entry, which cannot change until it pops,
    // so data stays stable under backpressure.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        unique case (state_q)
            StHdr:   out_data = {8'hA5, head.exc, head.intr, head.ecause,
                                 (head.drop != 8'd0), head.drop, head.seq};
            StAddr:  out_data = head.addr;
            StInsn: begin
                out_data = head.insn;
                out_last = ~(head.exc | head.intr);
            end
            StTval: begin
                out_data = head.tval;
                out_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= StIdle;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            seq_q       <= 8'd0;
            pend_drop_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            seq_q       <= seq_d;
            pend_drop_q <= pend_drop_d;
        end
    end

    // Storage needs no reset: entries are only read when occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_rec;
        end
    end

endmodule

// File: tb/tb_el2_trace_capture.sv
// Randomized bench for el2_trace_capture: a word-stream reference model plus directed
// literal checks of the header format, overflow, wrap and reset behaviour.
module tb_el2_trace_capture;
    import el2_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_l;
    el2_trace_pkt_t trace_pkt;
    logic           capture_en;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_data;
    logic           out_last;
    logic           busy;

    int total = 0;
    int bad   = 0;

    el2_trace_capture #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .trace_pkt  (trace_pkt),
        .capture_en (capture_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the expected word stream as {last, data}, and records held.
    logic [32:0] wq[$];
    int          occ;
    logic [7:0]  m_seq;
    logic [7:0]  m_drop;
    bit          m_cap, m_drp, m_hs;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wq.delete();
            occ    = 0;
            m_seq  = 8'd0;
            m_drop = 8'd0;
        end else begin
            m_cap = trace_pkt.trace_rv_i_valid_ip && capture_en && (occ < DEPTH);
            m_drp = trace_pkt.trace_rv_i_valid_ip && capture_en && !m_cap;
            m_hs  = (wq.size() != 0) && out_ready;
            if (m_hs) begin
                if (wq[0][32]) occ--;
                void'(wq.pop_front());
            end
            if (m_cap) begin
                wq.push_back({1'b0, 8'hA5, trace_pkt.trace_rv_i_exception_ip,
                              trace_pkt.trace_rv_i_interrupt_ip,
                              trace_pkt.trace_rv_i_ecause_ip, (m_drop != 8'd0), m_drop, m_seq});
                wq.push_back({1'b0, trace_pkt.trace_rv_i_address_ip});
                if (trace_pkt.trace_rv_i_exception_ip || trace_pkt.trace_rv_i_interrupt_ip) begin
                    wq.push_back({1'b0, trace_pkt.trace_rv_i_insn_ip});
                    wq.push_back({1'b1, trace_pkt.trace_rv_i_tval_ip});
                end else begin
                    wq.push_back({1'b1, trace_pkt.trace_rv_i_insn_ip});
                end
                occ++;
                m_seq  = m_seq + 8'd1;
                m_drop = 8'd0;
            end else if (m_drp && m_drop != 8'hFF) begin
                m_drop = m_drop + 8'd1;
            end
        end
    end

    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst_l) begin
            chk("out_valid", 32'(out_valid), 32'(wq.size() != 0));
            chk("busy", 32'(busy), 32'(occ != 0));
            if (wq.size() != 0) begin
                chk("out_data", out_data, wq[0][31:0]);
                chk("out_last", 32'(out_last), 32'(wq[0][32]));
            end
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit exc, input bit intr, input logic [4:0] ec,
                         input logic [31:0] a, input logic [31:0] ins, input logic [31:0] tv);
        trace_pkt.trace_rv_i_valid_ip     = v;
        trace_pkt.trace_rv_i_exception_ip = exc;
        trace_pkt.trace_rv_i_interrupt_ip = intr;
        trace_pkt.trace_rv_i_ecause_ip    = ec;
        trace_pkt.trace_rv_i_address_ip   = a;
        trace_pkt.trace_rv_i_insn_ip      = ins;
        trace_pkt.trace_rv_i_tval_ip      = tv;
        capture_en                        = 1'b1;
    endtask

    task automatic idle_in();
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        idle_in();
        for (int k = 0; k < 200 && busy; k++) step();
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l      = 1'b0;
        trace_pkt  = '0;
        capture_en = 1'b0;
        out_ready  = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        rst_l = 1'b1;
        step();

        // Plain record, streaming sink.
        out_ready = 1'b1;
        drive(1, 0, 0, 5'd0, 32'h0000_1000, 32'h0000_0013, 32'h0);
        step();
        idle_in();
        chk("r1_hdr", out_data, 32'hA500_0000);
        chk("r1_hdr_valid", 32'(out_valid), 32'd1);
        step();
        chk("r1_addr", out_data, 32'h0000_1000);
        step();
        chk("r1_insn", out_data, 32'h0000_0013);
        chk("r1_last", 32'(out_last), 32'd1);
        step();
        chk("r1_busy_fall", 32'(busy), 32'd0);

        // Exception record with TVAL word.
        drive(1, 1, 0, 5'd2, 32'h0000_2000, 32'h0010_0073, 32'hDEAD_BEEF);
        step();
        idle_in();
        chk("r2_hdr", out_data, 32'hA584_0001);
        step();
        chk("r2_addr", out_data, 32'h0000_2000);
        step();
        chk("r2_insn", out_data, 32'h0010_0073);
        chk("r2_insn_last", 32'(out_last), 32'd0);
        step();
        chk("r2_tval", out_data, 32'hDEAD_BEEF);
        chk("r2_tval_last", 32'(out_last), 32'd1);
        step();

        // Overflow: 4 captured, 3 dropped, reported in the next captured header.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, 5'd0, 32'h3000 + 32'(i), 32'h13, 32'h0);
            step();
        end
        idle_in();
        chk("ovf_hdr_stalled", out_data, 32'hA500_0002);
        drain("ovf_drain");
        drive(1, 0, 0, 5'd0, 32'h4000, 32'h13, 32'h0);
        step();
        idle_in();
        chk("ovf_drop_hdr", out_data, 32'hA501_0306);
        drain("ovf_drain2");

        // Randomized traffic with bursty backpressure.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 3 == 0) ? 1 : 3;
            drive($urandom_range(0, 2) != 0, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom);
            capture_en = ($urandom_range(0, 7) != 0);
            out_ready  = ($urandom_range(0, 3) < bias);
            step();
        end
        drain("rand_drain");

        // Sequence wrap across 260 records starting from reset.
        rst_l = 1'b0;
        #2;
        rst_l = 1'b1;
        step();
        for (int i = 0; i < 260; i++) begin
            drive(1, 0, 0, 5'd0, $urandom, $urandom, 32'h0);
            step();
            idle_in();
            chk("wrap_seq", {24'h0, out_data[7:0]}, 32'(i % 256));
            for (int k = 0; k < 10 && busy; k++) step();
        end

        // Drop counter saturation.
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 0, 5'd0, $urandom, $urandom, 32'h0);
            step();
        end
        drain("sat_drain");
        drive(1, 0, 0, 5'd0, 32'h5000, 32'h13, 32'h0);
        step();
        idle_in();
        chk("sat_hdr", out_data, 32'hA501_FF08);
        drain("sat_drain2");

        // Asynchronous reset in the middle of an ADDR word with two records queued.
        out_ready = 1'b0;
        drive(1, 0, 0, 5'd0, 32'h6000, 32'h13, 32'h0);
        step();
        drive(1, 0, 0, 5'd0, 32'h6004, 32'h13, 32'h0);
        step();
        idle_in();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mid_addr", out_data, 32'h0000_6000);
        #2;
        rst_l = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data", out_data, 32'd0);
        chk("mrst_last", 32'(out_last), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        step();
        rst_l     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        drive(1, 0, 0, 5'd0, 32'h7000, 32'h13, 32'h0);
        step();
        idle_in();
        chk("post_rst_hdr", out_data, 32'hA500_0000);
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
